// File: rtl/lrhls_mul_arbiter_pkg.sv
// lrhls_mul_arb_pkg
//   Shared constants for the shared-multiplier arbiter: operand and product
//   widths of the single 18x18 signed multiply, and a clog2 helper used to
//   size requester-index fields.
package lrhls_mul_arb_pkg;

    localparam int MUL_A_W = 18;
    localparam int MUL_B_W = 18;
    localparam int MUL_P_W = 36;

    // Width of an index able to name n items. Never narrower than one bit,
    // so a two-requester build still gets a real id field.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/lrhls_rr_arbiter.sv
// lrhls_rr_arbiter
//   Rotating-priority arbiter. The search starts at (ptr+1) mod NUM_REQ and
//   wraps; the first asserted request wins. Purely combinational: the pointer
//   register and its transfer-gated update live in the parent.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   ID_W     index of the last requester that transferred
//   grant    out  NUM_REQ  one-hot (or zero) grant
//   gnt_idx  out  ID_W     encoded index of the granted requester
//   gnt_any  out  1        some requester is granted
module lrhls_rr_arbiter
    import lrhls_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        // Offset 1 first, offset NUM_REQ last: the previous winner only wins
        // again when nobody else is asking.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                gnt_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lrhls_mul_arbiter.sv
// lrhls_mul_arbiter
//   Shares one pipelined 18x18 signed multiplier among NUM_REQ requesters.
//   A round-robin arbiter accepts at most one operand pair per cycle; each
//   36-bit product comes back on a single valid/ready result port tagged
//   with the requester index and the requester's opaque tag. The whole
//   pipeline freezes while a result is presented and not taken.
// Ports:
//   ap_clk     in   1              clock, rising edge
//   ap_rst     in   1              synchronous active-high reset
//   req_valid  in   NUM_REQ        per-requester operand valid
//   req_ready  out  NUM_REQ        per-requester accept, one-hot or zero
//   req_a      in   NUM_REQ*18     signed operand A, requester i at [18i+:18]
//   req_b      in   NUM_REQ*18     signed operand B, same packing
//   req_tag    in   NUM_REQ*TAG_W  tag, same packing
//   res_valid  out  1              result valid
//   res_ready  in   1              result accept
//   res_p      out  36             signed product a*b, full width
//   res_id     out  ID_W           originating requester
//   res_tag    out  TAG_W          tag returned unchanged
module lrhls_mul_arbiter
    import lrhls_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int MUL_LAT = 2,
    parameter  int TAG_W   = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*MUL_A_W-1:0]  req_a,
    input  logic [NUM_REQ*MUL_B_W-1:0]  req_b,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [MUL_P_W-1:0]   res_p,
    output logic [ID_W-1:0]             res_id,
    output logic [TAG_W-1:0]            res_tag
);

    // One pipeline slot as it travels towards the result port.
    typedef struct packed {
        logic                      valid;
        logic [ID_W-1:0]           id;
        logic [TAG_W-1:0]          tag;
        logic signed [MUL_P_W-1:0] p;
    } stage_t;

    logic [ID_W-1:0]           ptr;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           gnt_idx;
    logic                      gnt_any;
    logic                      stall;
    logic                      xfer;
    logic signed [MUL_A_W-1:0] a_sel;
    logic signed [MUL_B_W-1:0] b_sel;
    logic [TAG_W-1:0]          tag_sel;
    stage_t                    res_q;

    // ---------------------------------------------------------------- arbiter
    lrhls_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The only back-pressure source is the output slot: a presented result
    // that is not taken freezes every stage and closes the input side.
    assign stall = res_q.valid & ~res_ready;

    // Ready is also held low during reset so nothing is accepted on an edge
    // whose contents are about to be discarded.
    assign req_ready = (stall | ap_rst) ? '0 : grant;
    assign xfer      = gnt_any & ~stall & ~ap_rst;

    // Pointer starts at NUM_REQ-1 so requester 0 is searched first, and only
    // moves on a real transfer.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (xfer) begin
            ptr <= gnt_idx;
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        tag_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel   = req_a[i*MUL_A_W +: MUL_A_W];
                b_sel   = req_b[i*MUL_B_W +: MUL_B_W];
                tag_sel = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // --------------------------------------------------------------- pipeline
    // Bubbles travel through the stages like data, so a transfer always
    // surfaces exactly MUL_LAT unstalled edges later.
    generate
        if (MUL_LAT == 1) begin : g_lat1
            // Single stage: the registered product is the output.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    res_q <= '0;
                end else if (!stall) begin
                    res_q.valid <= xfer;
                    res_q.id    <= gnt_idx;
                    res_q.tag   <= tag_sel;
                    res_q.p     <= MUL_P_W'(a_sel) * MUL_P_W'(b_sel);
                end
            end
        end else begin : g_latn
            // Stage 1 holds raw operands (A/B input registers), stage 2 holds
            // the product (M register), further stages are output registers.
            logic                      s1_vld;
            logic signed [MUL_A_W-1:0] s1_a;
            logic signed [MUL_B_W-1:0] s1_b;
            logic [ID_W-1:0]           s1_id;
            logic [TAG_W-1:0]          s1_tag;
            stage_t                    mid [2:MUL_LAT];

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    s1_vld <= 1'b0;
                    s1_a   <= '0;
                    s1_b   <= '0;
                    s1_id  <= '0;
                    s1_tag <= '0;
                    for (int k = 2; k <= MUL_LAT; k++) mid[k] <= '0;
                end else if (!stall) begin
                    s1_vld <= xfer;
                    s1_a   <= a_sel;
                    s1_b   <= b_sel;
                    s1_id  <= gnt_idx;
                    s1_tag <= tag_sel;

                    // Both operands sign-extended to 36 bits: the full product
                    // of two 18-bit signed values always fits.
                    mid[2].valid <= s1_vld;
                    mid[2].id    <= s1_id;
                    mid[2].tag   <= s1_tag;
                    mid[2].p     <= MUL_P_W'(s1_a) * MUL_P_W'(s1_b);

                    for (int k = 3; k <= MUL_LAT; k++) mid[k] <= mid[k-1];
                end
            end

            assign res_q = mid[MUL_LAT];
        end
    endgenerate

    assign res_valid = res_q.valid;
    assign res_p     = res_q.p;
    assign res_id    = res_q.id;
    assign res_tag   = res_q.tag;

endmodule

// File: tb/tb_lrhls_mul_arbiter.sv
// Testbench for lrhls_mul_arbiter: per-requester operand queues feed a
// driver; a tracker checks each cycle's req_ready against a rotating-priority
// model and pushes expected products; a separate monitor pops and compares
// every consumed result, its latency, and output stability under stall.
module tb_lrhls_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 4;
    localparam int ID_W    = 2;

    typedef struct {
        int a;
        int b;
        int tag;
    } item_t;

    typedef struct {
        longint p;
        int     id;
        int     tag;
        int     cyc;
        int     stl;
    } exp_t;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*18-1:0]     req_a = '0;
    logic [NUM_REQ*18-1:0]     req_b = '0;
    logic [NUM_REQ*TAG_W-1:0]  req_tag = '0;
    logic                      res_valid;
    logic                      res_ready = 1'b1;
    logic signed [35:0]        res_p;
    logic [ID_W-1:0]           res_id;
    logic [TAG_W-1:0]          res_tag;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    stall_cnt = 0;
    int    m_ptr = NUM_REQ - 1;
    item_t pend [NUM_REQ][$];
    exp_t  sb[$];
    int    gnt_log[$];

    lrhls_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MUL_LAT (MUL_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .res_tag   (res_tag)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #2;
        end
    endtask

    task automatic push(input int i, input int a, input int b, input int tag);
        item_t it;
        it.a = a;
        it.b = b;
        it.tag = tag;
        pend[i].push_back(it);
    endtask

    function automatic int rnd_op();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic bit idle();
        bit r;
        r = (sb.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (!idle() && n < budget) begin
            step(1);
            n++;
        end
        chk(name, longint'(idle()), 1);
    endtask

    // Driver: presents the head of each requester's queue, held until taken.
    initial forever begin
        int av, bv, tv;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() > 0) begin
                av = pend[i][0].a;
                bv = pend[i][0].b;
                tv = pend[i][0].tag;
                req_valid[i] = 1'b1;
                req_a[i*18 +: 18] = av[17:0];
                req_b[i*18 +: 18] = bv[17:0];
                req_tag[i*TAG_W +: TAG_W] = tv[TAG_W-1:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Issue tracker: expected grant from the rotation rule, and expected
    // result for each observed handshake.
    always @(negedge ap_clk) begin
        logic [NUM_REQ-1:0] want;
        bit   found;
        int   k;
        item_t it;
        exp_t e;
        if (ap_rst) begin
            sb.delete();
            m_ptr = NUM_REQ - 1;
        end else begin
            want = '0;
            found = 1'b0;
            if (!(res_valid && !res_ready)) begin
                for (int d = 1; d <= NUM_REQ; d++) begin
                    k = (m_ptr + d) % NUM_REQ;
                    if (!found && req_valid[k]) begin
                        want[k] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk("req_ready", longint'(req_ready), longint'(want));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && pend[i].size() > 0) begin
                    it = pend[i].pop_front();
                    e.p = longint'(it.a) * longint'(it.b);
                    e.id = i;
                    e.tag = it.tag;
                    e.cyc = cyc;
                    e.stl = stall_cnt;
                    sb.push_back(e);
                    gnt_log.push_back(i);
                    m_ptr = i;
                end
            end
        end
    end

    // Result monitor.
    bit                 prev_stall = 1'b0;
    logic signed [35:0] prev_p;
    logic [ID_W-1:0]    prev_id;
    logic [TAG_W-1:0]   prev_tag;

    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", longint'(res_valid), 1);
                chk("hold_p", longint'(res_p), longint'(prev_p));
                chk("hold_id", longint'(res_id), longint'(prev_id));
                chk("hold_tag", longint'(res_tag), longint'(prev_tag));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got p=%0d id=%0d tag=%0d, expected no result (cycle %0d)",
                             res_p, res_id, res_tag, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("res_p", longint'(res_p), e.p);
                    chk("res_id", longint'(res_id), longint'(e.id));
                    chk("res_tag", longint'(res_tag), longint'(e.tag));
                    chk("latency", longint'(cyc), longint'(e.cyc + MUL_LAT + (stall_cnt - e.stl)));
                end
            end
            if (res_valid && !res_ready) stall_cnt++;
            prev_stall = res_valid && !res_ready;
            prev_p = res_p;
            prev_id = res_id;
            prev_tag = res_tag;
        end
    end

    initial begin
        // Reset state.
        step(3);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_p", longint'(res_p), 0);
        chk("rst_res_id", longint'(res_id), 0);
        chk("rst_res_tag", longint'(res_tag), 0);
        chk("rst_req_ready", longint'(req_ready), 0);
        ap_rst = 1'b0;
        step(1);

        // All requesters busy: strict rotation starting at 0.
        gnt_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) push(i, rnd_op(), rnd_op(), int'($urandom_range(0, 15)));
        drain("rot_drain", 200);
        chk("rot_count", longint'(gnt_log.size()), 8);
        for (int k = 0; k < gnt_log.size() && k < 8; k++) chk("rot_order", longint'(gnt_log[k]), longint'(k % NUM_REQ));

        // Single request, one result pulse.
        push(0, 3, -5, 1);
        drain("single_drain", 200);
        step(4);

        // Extreme operands.
        push(1, -131072, -131072, 2);
        push(1, -131072, 131071, 3);
        push(1, 131071, 131071, 4);
        drain("extreme_drain", 200);

        // Back-pressure with a full pipeline.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) push(i, rnd_op(), rnd_op(), int'($urandom_range(0, 15)));
        step(3);
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_req_ready", longint'(req_ready), 0);
            step(1);
        end
        res_ready = 1'b1;
        drain("bp_drain", 200);

        // Fairness: 2 twice, then 1 and 3 together -> 3 before 1.
        gnt_log.delete();
        push(2, 7, 9, 5);
        push(2, -11, 13, 6);
        drain("fair_drain_a", 200);
        push(1, 100, -3, 7);
        push(3, -42, -42, 8);
        drain("fair_drain_b", 200);
        chk("fair_count", longint'(gnt_log.size()), 4);
        if (gnt_log.size() == 4) begin
            chk("fair_g0", longint'(gnt_log[0]), 2);
            chk("fair_g1", longint'(gnt_log[1]), 2);
            chk("fair_g2", longint'(gnt_log[2]), 3);
            chk("fair_g3", longint'(gnt_log[3]), 1);
        end

        // Reset with two products in flight.
        begin
            int n;
            push(0, 1000, 1000, 9);
            push(0, -1000, 77, 10);
            n = 0;
            while (pend[0].size() > 0 && n < 50) begin
                step(1);
                n++;
            end
            chk("rstmid_issued", longint'(pend[0].size()), 0);
            ap_rst = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) push(i, rnd_op(), rnd_op(), int'($urandom_range(0, 15)));
            step(1);
            ap_rst = 1'b0;
            #1;
            chk("rstmid_res_valid", longint'(res_valid), 0);
            chk("rstmid_first_grant", longint'(req_ready), 1);
            drain("rstmid_drain", 200);
        end

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 3) == 0 && pend[i].size() < 3)
                    push(i, rnd_op(), rnd_op(), int'($urandom_range(0, 15)));
            res_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        res_ready = 1'b1;
        drain("rand_drain", 2000);
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
